// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one registered-output ALU between two valid/ready requesters.
// One operation in flight; the result returns on the owner's response channel.
module alu_share_arbiter #(
   parameter int DBITS  = 32,
   parameter int OPBITS = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OPBITS-1:0] req0_opsel,
   input  logic [DBITS-1:0]  req0_a,
   input  logic [DBITS-1:0]  req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OPBITS-1:0] req1_opsel,
   input  logic [DBITS-1:0]  req1_a,
   input  logic [DBITS-1:0]  req1_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DBITS-1:0]  rsp0_data,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DBITS-1:0]  rsp1_data,
   output logic [OPBITS-1:0] alu_opsel,
   output logic [DBITS-1:0]  alu_a,
   output logic [DBITS-1:0]  alu_b,
   input  logic [DBITS-1:0]  alu_out,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   // Handshake rule on every channel: a transfer happens on a rising edge
   // where valid and ready are both high; the sender holds its payload until then.
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CAPT = 2'd2, RESP = 2'd3} state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_grant_q, last_grant_d;
   logic [OPBITS-1:0]   alu_opsel_q, alu_opsel_d;
   logic [DBITS-1:0]    alu_a_q, alu_a_d;
   logic [DBITS-1:0]    alu_b_q, alu_b_d;
   logic                rsp0_valid_q, rsp0_valid_d;
   logic                rsp1_valid_q, rsp1_valid_d;
   logic [DBITS-1:0]    rsp0_data_q, rsp0_data_d;
   logic [DBITS-1:0]    rsp1_data_q, rsp1_data_d;

   logic grant0, grant1, accept, owner_rsp_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         alu_opsel_q  <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         alu_opsel_q  <= alu_opsel_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp1_data_q  <= rsp1_data_d;
      end
   end

   // On a tie the port that did not win last time is served.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant_q);
      grant1 = req1_valid & (~req0_valid | ~last_grant_q);
   end

   always_comb begin
      accept          = req0_ready | req1_ready;
      owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
      state_d         = state_q;
      owner_d         = owner_q;
      last_grant_d    = last_grant_q;
      alu_opsel_d     = alu_opsel_q;
      alu_a_d         = alu_a_q;
      alu_b_d         = alu_b_q;
      rsp0_valid_d    = rsp0_valid_q;
      rsp1_valid_d    = rsp1_valid_q;
      rsp0_data_d     = rsp0_data_q;
      rsp1_data_d     = rsp1_data_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d      = EXEC;
               owner_d      = req1_ready;
               last_grant_d = req1_ready;
               alu_opsel_d  = req1_ready ? req1_opsel : req0_opsel;
               alu_a_d      = req1_ready ? req1_a : req0_a;
               alu_b_d      = req1_ready ? req1_b : req0_b;
            end
         end
         EXEC: state_d = CAPT;
         CAPT: begin
            state_d = RESP;
            if (owner_q) begin
               rsp1_valid_d = 1'b1;
               rsp1_data_d  = alu_out;
            end else begin
               rsp0_valid_d = 1'b1;
               rsp0_data_d  = alu_out;
            end
         end
         RESP: begin
            if (owner_rsp_ready) begin
               state_d      = IDLE;
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Ready is masked while reset is held so no requester sees a handshake that is dropped.
   always_comb begin
      req0_ready = ~reset & (state_q == IDLE) & grant0;
      req1_ready = ~reset & (state_q == IDLE) & grant1;
      busy       = (state_q != IDLE);
      dbg_state  = state_q;
   end

   assign alu_opsel  = alu_opsel_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_data  = rsp0_data_q;
   assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small registered ALU model
// and hand-computed expected results.
module tb_alu_share_arbiter;

   logic        clk;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [5:0]  req0_opsel, req1_opsel;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_data, rsp1_data;
   logic [5:0]  alu_opsel;
   logic [31:0] alu_a, alu_b, alu_out;
   logic        busy;
   logic [1:0]  dbg_state;

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] exp0_q[$];
   logic [31:0] exp1_q[$];

   alu_share_arbiter #(.DBITS(32), .OPBITS(6)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opsel(req0_opsel),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opsel(req1_opsel),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .alu_opsel(alu_opsel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
      .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ALU model: ADD, SUB, MVHI, LT, and 6'h20 as a scaled add A + 4*B.
   function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         6'h00:   return a + b;
         6'h01:   return a - b;
         6'h0B:   return {b[15:0], 16'h0000};
         6'h12:   return {31'd0, ($signed(a) < $signed(b))};
         6'h20:   return a + (b << 2);
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) alu_out <= alu_f(alu_opsel, alu_a, alu_b);

   // scoreboard
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic drive0(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      req0_valid = 1'b1; req0_opsel = op; req0_a = a; req0_b = b;
   endtask

   task automatic drive1(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      req1_valid = 1'b1; req1_opsel = op; req1_a = a; req1_b = b;
   endtask

   task automatic wait_rsp(input bit port, input logic [31:0] exp, input string tag, output int waited);
      waited = 0;
      while (waited < 12 && !(port ? rsp1_valid : rsp0_valid)) begin
         step();
         waited++;
      end
      if (port ? rsp1_valid : rsp0_valid) begin
         check({tag, "_data"}, port ? rsp1_data : rsp0_data, exp);
         check({tag, "_other_valid"}, {31'd0, port ? rsp0_valid : rsp1_valid}, 32'd0);
      end else begin
         check({tag, "_timeout"}, {31'd0, port ? rsp1_valid : rsp0_valid}, 32'd1);
      end
   endtask

   logic [5:0]  f0_op [4];
   logic [31:0] f0_a  [4];
   logic [31:0] f0_b  [4];
   logic [5:0]  f1_op [4];
   logic [31:0] f1_a  [4];
   logic [31:0] f1_b  [4];

   initial begin
      int waited;
      reset = 1'b1;
      req0_valid = 0; req0_opsel = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_opsel = 0; req1_a = 0; req1_b = 0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;

      // reset state
      step(); step();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      check("rst_rsp0_data", rsp0_data, 32'd0);
      check("rst_rsp1_data", rsp1_data, 32'd0);
      check("rst_alu_opsel", {26'd0, alu_opsel}, 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      reset = 1'b0;

      // single op on port 0: 5 + 7
      step();
      drive0(6'h00, 32'd5, 32'd7);
      #1;
      check("single_ready0", {31'd0, req0_ready}, 32'd1);
      check("single_ready1", {31'd0, req1_ready}, 32'd0);
      step();
      req0_valid = 1'b0;
      #1;
      check("single_busy", {31'd0, busy}, 32'd1);
      check("single_alu_a", alu_a, 32'd5);
      check("single_alu_b", alu_b, 32'd7);
      check("single_ready0_busy", {31'd0, req0_ready}, 32'd0);
      wait_rsp(1'b0, 32'd12, "single", waited);
      check("single_latency", waited, 32'd2);
      step();
      #1;
      check("single_idle", {31'd0, busy}, 32'd0);
      check("single_rsp_clear", {31'd0, rsp0_valid}, 32'd0);

      // simultaneous requests after reset: port 0 first
      do_reset();
      drive0(6'h01, 32'd10, 32'd3);
      drive1(6'h12, -32'sd3, 32'd2);
      #1;
      check("tie_ready0", {31'd0, req0_ready}, 32'd1);
      check("tie_ready1", {31'd0, req1_ready}, 32'd0);
      step();
      req0_valid = 1'b0;
      #1;
      check("tie_ready1_busy", {31'd0, req1_ready}, 32'd0);
      wait_rsp(1'b0, 32'd7, "tie_p0", waited);
      step();
      #1;
      check("tie_ready1_idle", {31'd0, req1_ready}, 32'd1);
      step();
      req1_valid = 1'b0;
      wait_rsp(1'b1, 32'd1, "tie_p1", waited);
      step();
      drive0(6'h00, 32'd1, 32'd1);
      drive1(6'h00, 32'd2, 32'd2);
      #1;
      check("tie2_ready0", {31'd0, req0_ready}, 32'd1);
      check("tie2_ready1", {31'd0, req1_ready}, 32'd0);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp(1'b0, 32'd2, "tie2_p0", waited);
      step();

      // backpressure on port 1: 100 + 4*3
      rsp1_ready = 1'b0;
      drive1(6'h20, 32'd100, 32'd3);
      #1;
      check("bp_ready1", {31'd0, req1_ready}, 32'd1);
      step();
      req1_valid = 1'b0;
      drive0(6'h00, 32'd2, 32'd2);
      wait_rsp(1'b1, 32'd112, "bp", waited);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_hold_valid", {31'd0, rsp1_valid}, 32'd1);
         check("bp_hold_data", rsp1_data, 32'd112);
         check("bp_hold_busy", {31'd0, busy}, 32'd1);
         check("bp_hold_ready0", {31'd0, req0_ready}, 32'd0);
         step();
      end
      rsp1_ready = 1'b1;
      #1;
      check("bp_last_valid", {31'd0, rsp1_valid}, 32'd1);
      step();
      #1;
      check("bp_idle", {31'd0, busy}, 32'd0);
      check("bp_rsp_clear", {31'd0, rsp1_valid}, 32'd0);
      check("bp_ready0_idle", {31'd0, req0_ready}, 32'd1);
      step();
      req0_valid = 1'b0;
      wait_rsp(1'b0, 32'd4, "bp_p0", waited);
      step();

      // reset while an op is executing
      drive0(6'h01, 32'd5, 32'd2);
      #1;
      check("mid_ready0", {31'd0, req0_ready}, 32'd1);
      step();
      req0_valid = 1'b0;
      drive1(6'h00, 32'd20, 32'd22);
      #1;
      check("mid_busy_exec", {31'd0, busy}, 32'd1);
      check("mid_alu_a_exec", alu_a, 32'd5);
      reset = 1'b1;
      #1;
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      check("mid_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      check("mid_alu_opsel", {26'd0, alu_opsel}, 32'd0);
      check("mid_alu_a", alu_a, 32'd0);
      check("mid_ready1_in_reset", {31'd0, req1_ready}, 32'd0);
      step(); step();
      check("mid_no_rsp0", {31'd0, rsp0_valid}, 32'd0);
      reset = 1'b0;
      #1;
      check("mid_ready1_after", {31'd0, req1_ready}, 32'd1);
      step();
      req1_valid = 1'b0;
      wait_rsp(1'b1, 32'd42, "mid_p1", waited);
      step();

      // back-to-back fairness, both ports valid continuously
      f0_op = '{6'h00, 6'h01, 6'h0B, 6'h12};
      f0_a  = '{32'd1, 32'd100, 32'd0, 32'd5};
      f0_b  = '{32'd2, 32'd1, 32'h0000_1234, 32'd9};
      f1_op = '{6'h00, 6'h12, 6'h01, 6'h0B};
      f1_a  = '{32'hFFFF_FFFF, 32'd9, 32'd0, 32'd0};
      f1_b  = '{32'd1, 32'd5, 32'd1, 32'h0000_BEEF};
      exp0_q = '{32'd3, 32'd99, 32'h1234_0000, 32'd1};
      exp1_q = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hBEEF_0000};
      do_reset();
      begin
         int  i0, i1, n_acc, last_c;
         bit  exp_port, adv0, adv1;
         i0 = 0; i1 = 0; n_acc = 0; last_c = -1; exp_port = 1'b0; adv0 = 0; adv1 = 0;
         for (int c = 0; c < 80; c++) begin
            if (adv0) i0++;
            if (adv1) i1++;
            adv0 = 0; adv1 = 0;
            if (n_acc < 8) begin
               drive0(f0_op[(i0 < 4) ? i0 : 3], f0_a[(i0 < 4) ? i0 : 3], f0_b[(i0 < 4) ? i0 : 3]);
               drive1(f1_op[(i1 < 4) ? i1 : 3], f1_a[(i1 < 4) ? i1 : 3], f1_b[(i1 < 4) ? i1 : 3]);
            end else begin
               req0_valid = 1'b0;
               req1_valid = 1'b0;
            end
            #1;
            check("fair_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (rsp0_valid) begin
               if (exp0_q.size() > 0) check("fair_rsp0", rsp0_data, exp0_q.pop_front());
               else check("fair_rsp0_extra", {31'd0, rsp0_valid}, 32'd0);
            end
            if (rsp1_valid) begin
               if (exp1_q.size() > 0) check("fair_rsp1", rsp1_data, exp1_q.pop_front());
               else check("fair_rsp1_extra", {31'd0, rsp1_valid}, 32'd0);
            end
            if (req0_ready | req1_ready) begin
               check("fair_grant", {31'd0, req1_ready}, {31'd0, exp_port});
               if (last_c >= 0) check("fair_gap", c - last_c, 32'd4);
               last_c   = c;
               exp_port = ~exp_port;
               n_acc++;
               if (req0_ready) adv0 = 1; else adv1 = 1;
            end
            if (n_acc == 8 && exp0_q.size() == 0 && exp1_q.size() == 0) break;
            step();
         end
         check("fair_accepts", n_acc, 32'd8);
         check("fair_queues_empty", exp0_q.size() + exp1_q.size(), 32'd0);
      end

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
